// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register with load-use hazard bubble insertion (optional via HAZARD_DETECT_EN).
// Latency: exactly one clk from ID_ inputs to EX_ outputs; ID_stall is combinational.
// Backpressure: hold freezes the whole register; flush/stall replace the incoming instruction with a bubble.
module id_ex_pipeline_reg #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            hold,
  input  logic            flush,
  input  logic            ID_cntl_MemWrite,
  input  logic            ID_cntl_MemRead,
  input  logic            ID_cntl_RegWrite,
  input  logic            ID_cntl_Branch,
  input  logic [2:0]      ID_sel_MemToReg,
  input  logic [1:0]      ID_sel_ALUSrc,
  input  logic [1:0]      ID_sel_jump,
  input  logic [3:0]      ID_ALUOp,
  input  logic [2:0]      ID_funct,
  input  logic [XLEN-1:0] ID_PC,
  input  logic [XLEN-1:0] ID_data1,
  input  logic [XLEN-1:0] ID_data2,
  input  logic [XLEN-1:0] ID_imm,
  input  logic [4:0]      ID_rs1,
  input  logic [4:0]      ID_rs2,
  input  logic [4:0]      ID_rd,
  output logic            EX_cntl_MemWrite,
  output logic            EX_cntl_MemRead,
  output logic            EX_cntl_RegWrite,
  output logic            EX_cntl_Branch,
  output logic [2:0]      EX_sel_MemToReg,
  output logic [1:0]      EX_sel_ALUSrc,
  output logic [1:0]      EX_sel_jump,
  output logic [3:0]      EX_ALUOp,
  output logic [2:0]      EX_funct,
  output logic [XLEN-1:0] EX_PC,
  output logic [XLEN-1:0] EX_data1,
  output logic [XLEN-1:0] EX_data2,
  output logic [XLEN-1:0] EX_imm,
  output logic [4:0]      EX_rs1,
  output logic [4:0]      EX_rs2,
  output logic [4:0]      EX_rd,
  output logic            EX_valid,
  output logic            ID_stall
);

  typedef struct packed {
    logic            mem_write;
    logic            mem_read;
    logic            reg_write;
    logic            branch;
    logic [2:0]      sel_mem_to_reg;
    logic [1:0]      sel_alu_src;
    logic [1:0]      sel_jump;
    logic [3:0]      alu_op;
    logic [2:0]      funct;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] data1;
    logic [XLEN-1:0] data2;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
  } ex_t;

  // VALID: EX holds a real instruction; BUBBLE: EX holds a killed/empty slot.
  typedef enum logic {BUBBLE = 1'b0, VALID = 1'b1} state_t;

  state_t state_q, state_d;
  ex_t    ex_q, ex_d;
  ex_t    id_w;
  logic   stall_w;

  assign id_w = '{
    mem_write:      ID_cntl_MemWrite,
    mem_read:       ID_cntl_MemRead,
    reg_write:      ID_cntl_RegWrite,
    branch:         ID_cntl_Branch,
    sel_mem_to_reg: ID_sel_MemToReg,
    sel_alu_src:    ID_sel_ALUSrc,
    sel_jump:       ID_sel_jump,
    alu_op:         ID_ALUOp,
    funct:          ID_funct,
    pc:             ID_PC,
    data1:          ID_data1,
    data2:          ID_data2,
    imm:            ID_imm,
    rs1:            ID_rs1,
    rs2:            ID_rs2,
    rd:             ID_rd
  };

`ifdef HAZARD_DETECT_EN
  // Load in EX whose destination matches either source of the decoding instruction.
  // rs1/rs2 are compared even if unused by the instruction, and x0 never stalls.
  assign stall_w = ~reset & ~hold & ~flush & (state_q == VALID) & ex_q.mem_read &
                   (ex_q.rd != 5'd0) & ((ex_q.rd == ID_rs1) | (ex_q.rd == ID_rs2));
`else
  // Without detection, software schedules the load delay slot.
  assign stall_w = 1'b0;
`endif

  assign ID_stall = stall_w;

  // Next state: hold retains, flush/stall load a bubble, otherwise load the ID instruction.
  always_comb begin
    ex_d    = ex_q;
    state_d = state_q;
    if (!hold) begin
      ex_d = id_w;
      if (flush || stall_w) begin
        ex_d.mem_write = 1'b0;
        ex_d.mem_read  = 1'b0;
        ex_d.reg_write = 1'b0;
        ex_d.branch    = 1'b0;
        ex_d.sel_jump  = 2'b00;
        ex_d.rd        = 5'd0;
        state_d        = BUBBLE;
      end else begin
        state_d        = VALID;
      end
    end
  end

  // Register update; synchronous reset overrides hold and flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q    <= '0;
      state_q <= BUBBLE;
    end else begin
      ex_q    <= ex_d;
      state_q <= state_d;
    end
  end

  assign EX_cntl_MemWrite = ex_q.mem_write;
  assign EX_cntl_MemRead  = ex_q.mem_read;
  assign EX_cntl_RegWrite = ex_q.reg_write;
  assign EX_cntl_Branch   = ex_q.branch;
  assign EX_sel_MemToReg  = ex_q.sel_mem_to_reg;
  assign EX_sel_ALUSrc    = ex_q.sel_alu_src;
  assign EX_sel_jump      = ex_q.sel_jump;
  assign EX_ALUOp         = ex_q.alu_op;
  assign EX_funct         = ex_q.funct;
  assign EX_PC            = ex_q.pc;
  assign EX_data1         = ex_q.data1;
  assign EX_data2         = ex_q.data2;
  assign EX_imm           = ex_q.imm;
  assign EX_rs1           = ex_q.rs1;
  assign EX_rs2           = ex_q.rs2;
  assign EX_rd            = ex_q.rd;
  assign EX_valid         = (state_q == VALID);

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Scoreboard bench for id_ex_pipeline_reg: driver pushes predicted EX contents and ID_stall,
// a negedge monitor pops and compares. Reference model follows the update-priority rules.
module tb_id_ex_pipeline_reg;
  localparam int XLEN = 32;

  typedef struct packed {
    logic            mem_write;
    logic            mem_read;
    logic            reg_write;
    logic            branch;
    logic [2:0]      sel_mem_to_reg;
    logic [1:0]      sel_alu_src;
    logic [1:0]      sel_jump;
    logic [3:0]      alu_op;
    logic [2:0]      funct;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] data1;
    logic [XLEN-1:0] data2;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            valid;
  } ex_t;

  typedef struct {
    logic reset;
    logic hold;
    logic flush;
    ex_t  f;
  } stim_t;

  typedef struct {
    ex_t  ex;
    logic stall;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, hold, flush;
  ex_t  id;   // valid field unused on the input side
  ex_t  act;
  logic EX_valid, ID_stall;

  id_ex_pipeline_reg #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .hold(hold), .flush(flush),
    .ID_cntl_MemWrite(id.mem_write), .ID_cntl_MemRead(id.mem_read),
    .ID_cntl_RegWrite(id.reg_write), .ID_cntl_Branch(id.branch),
    .ID_sel_MemToReg(id.sel_mem_to_reg), .ID_sel_ALUSrc(id.sel_alu_src),
    .ID_sel_jump(id.sel_jump), .ID_ALUOp(id.alu_op), .ID_funct(id.funct),
    .ID_PC(id.pc), .ID_data1(id.data1), .ID_data2(id.data2), .ID_imm(id.imm),
    .ID_rs1(id.rs1), .ID_rs2(id.rs2), .ID_rd(id.rd),
    .EX_cntl_MemWrite(act.mem_write), .EX_cntl_MemRead(act.mem_read),
    .EX_cntl_RegWrite(act.reg_write), .EX_cntl_Branch(act.branch),
    .EX_sel_MemToReg(act.sel_mem_to_reg), .EX_sel_ALUSrc(act.sel_alu_src),
    .EX_sel_jump(act.sel_jump), .EX_ALUOp(act.alu_op), .EX_funct(act.funct),
    .EX_PC(act.pc), .EX_data1(act.data1), .EX_data2(act.data2), .EX_imm(act.imm),
    .EX_rs1(act.rs1), .EX_rs2(act.rs2), .EX_rd(act.rd),
    .EX_valid(EX_valid), .ID_stall(ID_stall)
  );
  assign act.valid = EX_valid;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_pushed = 0;
  int   n_popped = 0;
  int   n_stalls = 0;
  exp_t sb[$];
  ex_t  mdl;      // predicted EX contents after the next edge is taken into account

  // Expected load-use stall from the architectural rule, given what is in EX now.
  function automatic logic model_stall(input stim_t s, input ex_t ex);
`ifdef HAZARD_DETECT_EN
    if (s.reset || s.hold || s.flush) return 1'b0;
    return ex.valid && ex.mem_read && ex.rd != 5'd0 && (ex.rd == s.f.rs1 || ex.rd == s.f.rs2);
`else
    return 1'b0;
`endif
  endfunction

  // What EX should contain after an edge with stimulus s applied.
  function automatic ex_t model_next(input stim_t s, input ex_t ex, input logic stall);
    ex_t n;
    if (s.reset) return '0;
    if (s.hold) return ex;
    n = s.f;
    if (s.flush || stall) begin
      n.mem_write = 0; n.mem_read = 0; n.reg_write = 0; n.branch = 0;
      n.sel_jump = 0; n.rd = 0; n.valid = 0;
    end else begin
      n.valid = 1;
    end
    return n;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.reset = ($urandom_range(0, 31) == 0);
    s.hold  = ($urandom_range(0, 7) == 0);
    s.flush = ($urandom_range(0, 7) == 0);
    s.f.mem_write = $urandom_range(0, 1);
    s.f.mem_read  = $urandom_range(0, 1);
    s.f.reg_write = $urandom_range(0, 1);
    s.f.branch    = $urandom_range(0, 1);
    s.f.sel_mem_to_reg = 3'($urandom);
    s.f.sel_alu_src    = 2'($urandom);
    s.f.sel_jump       = 2'($urandom);
    s.f.alu_op         = 4'($urandom);
    s.f.funct          = 3'($urandom);
    s.f.pc    = $urandom;
    s.f.data1 = $urandom;
    s.f.data2 = $urandom;
    s.f.imm   = $urandom;
    s.f.rs1   = 5'($urandom_range(0, 7));
    s.f.rs2   = 5'($urandom_range(0, 7));
    s.f.rd    = 5'($urandom_range(0, 7));
    s.f.valid = 1'b0;
    return s;
  endfunction

  // Wait for an edge, drive the next cycle's inputs, push the prediction for this cycle.
  task automatic apply(input stim_t s);
    exp_t e;
    @(posedge clk);
    #1;
    reset = s.reset; hold = s.hold; flush = s.flush; id = s.f;
    e.ex    = mdl;
    e.stall = model_stall(s, mdl);
    if (e.stall) n_stalls++;
    sb.push_back(e);
    n_pushed++;
    mdl = model_next(s, mdl, e.stall);
  endtask

  // Monitor: compare DUT state and combinational stall mid-cycle.
  exp_t m_e;
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      m_e = sb.pop_front();
      n_popped++;
      n_tests++;
      if (act !== m_e.ex) begin
        n_fail++;
        $display("FAIL ex_regs t=%0t actual=%h required=%h", $time, act, m_e.ex);
      end
      n_tests++;
      if (ID_stall !== m_e.stall) begin
        n_fail++;
        $display("FAIL id_stall t=%0t actual=%b required=%b", $time, ID_stall, m_e.stall);
      end
    end
  end

  stim_t s;
  initial begin
    // Reset with nonzero inputs; the first edge clears EX.
    s = rand_stim();
    s.f.mem_write = 1; s.f.mem_read = 1; s.f.reg_write = 1; s.f.branch = 1;
    s.f.pc = 32'hDEAD_BEEF; s.f.rd = 5'd7; s.f.rs1 = 5'd7;
    s.reset = 1; s.hold = 1; s.flush = 1;
    reset = s.reset; hold = s.hold; flush = s.flush; id = s.f;
    mdl = '0;
    apply(s);                       // still in reset: stall must be 0
    s.reset = 0; s.hold = 0; s.flush = 0;

    // Normal load: PC 0x40, ALUOp 0010, rd 5.
    s = rand_stim(); s.reset = 0; s.hold = 0; s.flush = 0;
    s.f.pc = 32'h0000_0040; s.f.alu_op = 4'b0010; s.f.rd = 5'd5; s.f.mem_read = 0;
    apply(s);

    // Load-use: lw x5, then consumer of x5, then repeat consumer.
    s = rand_stim(); s.reset = 0; s.hold = 0; s.flush = 0;
    s.f.mem_read = 1; s.f.rd = 5'd5; apply(s);
    s.f.mem_read = 0; s.f.reg_write = 1; s.f.rs1 = 5'd5; s.f.rs2 = 5'd1; s.f.rd = 5'd6; apply(s);
    apply(s);
    apply(s);

    // x0 destination load never stalls.
    s.f.mem_read = 1; s.f.rd = 5'd0; apply(s);
    s.f.mem_read = 0; s.f.rs1 = 5'd0; s.f.rs2 = 5'd0; s.f.rd = 5'd3; apply(s);

    // Flush together with a load-use condition.
    s.f.mem_read = 1; s.f.rd = 5'd5; apply(s);
    s.f.mem_read = 0; s.f.mem_write = 1; s.f.rs2 = 5'd5; s.flush = 1; apply(s);
    s.flush = 0; apply(s);

    // Hold for three cycles with changing inputs and flush asserted, behind a pending load-use.
    s.f.mem_read = 1; s.f.rd = 5'd4; s.f.mem_write = 0; apply(s);
    for (int i = 0; i < 3; i++) begin
      s = rand_stim(); s.reset = 0; s.hold = 1; s.flush = 1; s.f.rs1 = 5'd4;
      apply(s);
    end
    s.hold = 0; s.flush = 0; apply(s);

    // Reset while a load-use stall is pending.
    s.f.mem_read = 1; s.f.rd = 5'd2; apply(s);
    s.f.rs1 = 5'd2; s.reset = 1; apply(s);
    s.reset = 0; apply(s);

    // Random traffic.
    for (int i = 0; i < 500; i++) apply(rand_stim());

    @(posedge clk);
    @(negedge clk);
    #1;
    n_tests++;
    if (sb.size() != 0 || n_popped != n_pushed) begin
      n_fail++;
      $display("FAIL scoreboard_drain actual=%0d popped required=%0d", n_popped, n_pushed);
    end
`ifdef HAZARD_DETECT_EN
    n_tests++;
    if (n_stalls == 0) begin
      n_fail++;
      $display("FAIL stall_coverage actual=%0d required=nonzero", n_stalls);
    end
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout actual=%0t required=finish", $time);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/id_ex_pipeline_reg.md
ID_EX_PIPELINE_REG -- requirements
Module: id_ex_pipeline_reg

Interface
REQ-001 Parameter XLEN, default 32, datapath width of PC, operand and immediate fields.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 hold  input  1  freeze entire ID/EX register (downstream memory wait).
REQ-005 flush  input  1  EX-stage branch/jump taken; kill instruction entering EX.
REQ-006 ID_cntl_MemWrite, ID_cntl_MemRead, ID_cntl_RegWrite, ID_cntl_Branch  input  1 each  control unit outputs.
REQ-007 ID_sel_MemToReg  input  3; ID_sel_ALUSrc  input  2; ID_sel_jump  input  2; ID_ALUOp  input  4  control unit selects.
REQ-008 ID_funct  input  3  instruction funct3 (branch condition, load/store size).
REQ-009 ID_PC, ID_data1, ID_data2, ID_imm  input  XLEN each  PC, register-file read data, sign-extended immediate.
REQ-010 ID_rs1, ID_rs2, ID_rd  input  5 each  register specifiers of decoding instruction.
REQ-011 EX_* outputs: same names/widths as REQ-006..REQ-010 with EX_ prefix, registered.
REQ-012 EX_valid  output  1  registered; EX stage holds a real instruction.
REQ-013 ID_stall  output  1  combinational; hold PC and IF/ID this cycle.

Function
REQ-014 Update priority per rising edge: reset > hold > flush > load-use bubble > normal load.
REQ-015 Normal load: every EX_ register SHALL take its ID_ input; EX_valid <= 1; latency exactly 1 cycle.
REQ-016 hold=1: all EX_ registers and EX_valid SHALL retain value, regardless of flush/stall.
REQ-017 Bubble (flush=1, or ID_stall=1 with hold=0): EX_cntl_MemWrite, MemRead, RegWrite, Branch <= 0, EX_sel_jump <= 0, EX_rd <= 0, EX_valid <= 0; data/select fields SHALL load ID_ values (don't-care).
REQ-018 ID_stall SHALL be 1 iff EX_cntl_MemRead=1 and EX_valid=1 and EX_rd!=0 and (EX_rd==ID_rs1 or EX_rd==ID_rs2), with hold=0 and flush=0.
REQ-019 ID_stall SHALL be 0 while hold=1, flush=1 or reset=1.
REQ-020 Load-use stall SHALL last exactly one cycle: after bubble, EX_cntl_MemRead=0 so ID_stall deasserts.
REQ-021 rd=x0 never triggers stall; rs1/rs2 compared even when instruction does not use them (conservative).
REQ-022 flush and ID_stall in same cycle: flush wins; bubble inserted, ID_stall=0.
REQ-023 Two-state view: VALID (EX_valid=1) / BUBBLE (EX_valid=0); transitions only via REQ-015/REQ-017; hold keeps state.

Reset
REQ-024 reset=1 at edge SHALL clear every EX_ output to 0 and EX_valid to 0, overriding hold and flush.
REQ-025 Reset mid-stall SHALL drop pending stall; first post-reset cycle ID_stall=0.

Configuration
REQ-026 Macro HAZARD_DETECT_EN: defined -> REQ-018..REQ-022 load-use detection active.
REQ-027 Undefined -> ID_stall tied 0, no detection logic, only flush/hold/reset create bubbles; software must schedule load delay.

Verification
REQ-028 Reset: reset=1 one edge with ID_ inputs nonzero -> all EX_ outputs 0, EX_valid=0.
REQ-029 Normal: ID_PC=0x0000_0040, ID_ALUOp=4'b0010, ID_rd=5 -> next edge EX_PC=0x40, EX_ALUOp=0010, EX_rd=5, EX_valid=1.
REQ-030 Load-use: lw x5 in EX (MemRead=1, rd=5), ID_rs1=5 -> ID_stall=1; next edge EX_valid=0, EX_cntl_RegWrite=0; following cycle ID_stall=0.
REQ-031 x0: EX load rd=0, ID_rs1=0 -> ID_stall=0, normal load.
REQ-032 Flush+stall: load-use condition and flush=1 together -> ID_stall=0, bubble, EX_cntl_MemWrite=0.
REQ-033 Hold: hold=1 for 3 cycles with changing ID_ inputs and flush=1 -> EX_ outputs unchanged; without HAZARD_DETECT_EN repeat REQ-030 -> ID_stall=0, load proceeds.
